// File: rtl/wb_unit_pkg.sv
// Shared types for the writeback stage: FSM state encoding and load-size codes.
package wb_unit_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } wb_state_e;

   localparam logic [1:0] LD_BYTE = 2'd0;
   localparam logic [1:0] LD_HALF = 2'd1;
   localparam logic [1:0] LD_WORD = 2'd2;

endpackage

// File: rtl/wb_unit_load_align.sv
// Combinational load formatter: selects the addressed byte/half from an aligned word and extends it.
module load_align
   import wb_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [1:0]  addr_lo,
   output logic [31:0] value
);

   logic [15:0] shifted;

   always_comb begin
      // addr_lo=3 leaves only the top byte; the upper half is zero-padded rather than trapping
      case (addr_lo)
         2'd0:    shifted = rdata[15:0];
         2'd1:    shifted = rdata[23:8];
         2'd2:    shifted = rdata[31:16];
         default: shifted = {8'd0, rdata[31:24]};
      endcase
   end

   always_comb begin
      value = rdata;
      case (size)
         LD_BYTE: value = is_unsigned ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         LD_HALF: value = is_unsigned ? {16'd0, shifted} : {{16{shifted[15]}}, shifted};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: accepts one retiring instruction, waits for load data if needed, writes the rf once.
// Optional macro WB_UNIT_PERF_EN adds commit and load-stall counters (tied to 0 when undefined).
module wb_unit
   import wb_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic [DATA_WIDTH-1:0] in_result,
   input  logic                  in_is_load,
   input  logic [1:0]            in_ld_size,
   input  logic                  in_ld_unsigned,
   input  logic [1:0]            in_addr_lo,
   input  logic                  mem_rvalid,
   output logic                  mem_rready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  commit,
   output logic [31:0]           perf_commits,
   output logic [31:0]           perf_ld_stall
);

   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("wb_unit: load formatting supports only DATA_WIDTH=32");
   end

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // Senders hold their payload stable while valid is high and ready is low.

   wb_state_e state, state_nxt;

   logic [ADDR_WIDTH-1:0] rd_q;
   logic [1:0]            size_q;
   logic [1:0]            lo_q;
   logic                  uns_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [31:0]           ld_value;
   logic                  accept;
   logic                  mem_fire;

   load_align u_load_align (
      .rdata       (mem_rdata),
      .size        (size_q),
      .is_unsigned (uns_q),
      .addr_lo     (lo_q),
      .value       (ld_value)
   );

   assign in_ready   = (state == IDLE);
   assign mem_rready = (state == WAIT_MEM);
   assign accept     = in_ready && in_valid;
   assign mem_fire   = mem_rready && mem_rvalid;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (in_valid) state_nxt = in_is_load ? WAIT_MEM : WRITE;
         WAIT_MEM: if (mem_rvalid) state_nxt = WRITE;
         WRITE:    state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rd_q    <= '0;
         size_q  <= LD_WORD;
         lo_q    <= 2'd0;
         uns_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            rd_q   <= in_rd;
            size_q <= in_ld_size;
            lo_q   <= in_addr_lo;
            uns_q  <= in_ld_unsigned;
            if (!in_is_load) begin
               waddr_q <= in_rd;
               wdata_q <= in_result;
            end
         end
         // write port registers only change on entry to WRITE so they hold between writes
         if (mem_fire) begin
            waddr_q <= rd_q;
            wdata_q <= ld_value;
         end
      end
   end

   assign commit   = (state == WRITE);
   assign rf_wen   = commit && (waddr_q != '0);
   assign rf_waddr = waddr_q;
   assign rf_wdata = wdata_q;

`ifdef WB_UNIT_PERF_EN
   logic [31:0] commits_q;
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         commits_q <= 32'd0;
         stall_q   <= 32'd0;
      end else begin
         if (commit) commits_q <= commits_q + 32'd1;
         if (state == WAIT_MEM) stall_q <= stall_q + 32'd1;
      end
   end

   assign perf_commits  = commits_q;
   assign perf_ld_stall = stall_q;
`else
   assign perf_commits  = 32'd0;
   assign perf_ld_stall = 32'd0;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios plus randomized traffic against a behavioural load model.
module tb_wb_unit;
   import wb_unit_pkg::*;

   localparam int AW = 5;
   localparam int DW = 32;
`ifdef WB_UNIT_PERF_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_rd = '0;
   logic [DW-1:0] in_result = '0;
   logic          in_is_load = 1'b0;
   logic [1:0]    in_ld_size = 2'd0;
   logic          in_ld_unsigned = 1'b0;
   logic [1:0]    in_addr_lo = 2'd0;
   logic          mem_rvalid = 1'b0;
   logic          mem_rready;
   logic [DW-1:0] mem_rdata = '0;
   logic          rf_wen;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          commit;
   logic [31:0]   perf_commits;
   logic [31:0]   perf_ld_stall;

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] exp_q[$];
   int unsigned exp_commits = 0;
   int unsigned exp_stall = 0;

   wb_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_result(in_result),
      .in_is_load(in_is_load), .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
      .in_addr_lo(in_addr_lo),
      .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .commit(commit),
      .perf_commits(perf_commits), .perf_ld_stall(perf_ld_stall)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // Reference load formatting computed arithmetically from the access rules.
   function automatic logic [31:0] ref_load(input logic [31:0] word, input int size,
                                            input bit uns, input int lo);
      longint v;
      if (size == 0) begin
         v = (word >> (8 * lo)) & 32'hFF;
         if (!uns && v >= 128) v -= 256;
      end else if (size == 1) begin
         v = (word >> (8 * lo)) & 32'hFFFF;
         if (!uns && v >= 32768) v -= 65536;
      end else begin
         v = word;
      end
      return v[31:0];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; mem_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_commits = 0; exp_stall = 0;
      exp_q.delete();
   endtask

   task automatic issue(input logic [AW-1:0] rd, input logic [DW-1:0] res, input bit ld,
                        input logic [1:0] size, input bit uns, input logic [1:0] lo);
      int waited;
      waited = 0;
      in_rd = rd; in_result = res; in_is_load = ld; in_ld_size = size;
      in_ld_unsigned = uns; in_addr_lo = lo; in_valid = 1'b1;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_ready: in_ready=%b after %0d cycles, want 1", in_ready, waited);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic respond(input logic [DW-1:0] data, input int delay);
      for (int i = 0; i < delay; i++) begin
         mem_rvalid = 1'b0; mem_rdata = $urandom;
         @(negedge clk);
      end
      mem_rvalid = 1'b1; mem_rdata = data;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = $urandom;
      exp_stall += delay + 1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", rf_wen); end
      checks++; if (commit !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b want 0", commit); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (mem_rready !== 1'b0) begin errors++; $display("FAIL reset_mem_rready: got %b want 0", mem_rready); end
      checks++; if (rf_waddr !== '0 || rf_wdata !== '0) begin errors++; $display("FAIL reset_wport: waddr=%0d wdata=%h want 0/0", rf_waddr, rf_wdata); end
      checks++; if (perf_commits !== 32'd0 || perf_ld_stall !== 32'd0) begin errors++; $display("FAIL reset_perf: commits=%0d stall=%0d want 0/0", perf_commits, perf_ld_stall); end
   endtask

   task automatic test_alu();
      issue(5'd5, 32'hDEADBEEF, 1'b0, LD_WORD, 1'b0, 2'd0);
      exp_commits++;
      checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL alu_wen: got %b want 1", rf_wen); end
      checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr: got %0d want 5", rf_waddr); end
      checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wdata: got %h want deadbeef", rf_wdata); end
      checks++; if (commit !== 1'b1) begin errors++; $display("FAIL alu_commit: got %b want 1", commit); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL alu_busy: in_ready=%b want 0", in_ready); end
      // stray read data outside WAIT_MEM must be ignored
      mem_rvalid = 1'b1; mem_rdata = 32'h0BAD0BAD;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alu_ready_after: got %b want 1", in_ready); end
      checks++; if (commit !== 1'b0 || rf_wen !== 1'b0) begin errors++; $display("FAIL alu_single_pulse: commit=%b wen=%b want 0/0", commit, rf_wen); end
      checks++; if (rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_hold: waddr=%0d wdata=%h want 5/deadbeef", rf_waddr, rf_wdata); end
      @(negedge clk);
      mem_rvalid = 1'b0;
      checks++; if (mem_rready !== 1'b0 || commit !== 1'b0) begin errors++; $display("FAIL alu_stray_rvalid: mem_rready=%b commit=%b want 0/0", mem_rready, commit); end
   endtask

   task automatic test_load();
      issue(5'd7, 32'h11111111, 1'b1, LD_BYTE, 1'b0, 2'd2);
      checks++; if (mem_rready !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL lb_wait: mem_rready=%b in_ready=%b want 1/0", mem_rready, in_ready); end
      // a new instruction offered while busy must not be taken
      in_valid = 1'b1; in_is_load = 1'b0; in_rd = 5'd9; in_result = 32'h99999999;
      respond(32'h12803456, 3);
      exp_commits++;
      in_valid = 1'b0;
      checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7) begin errors++; $display("FAIL lb_write: wen=%b waddr=%0d want 1/7", rf_wen, rf_waddr); end
      checks++; if (rf_wdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_wdata: got %h want ffffff80", rf_wdata); end
      @(negedge clk);
      checks++; if (commit !== 1'b0 || rf_waddr !== 5'd7) begin errors++; $display("FAIL busy_ignored: commit=%b waddr=%0d want 0/7", commit, rf_waddr); end
      issue(5'd8, 32'h0, 1'b1, LD_HALF, 1'b1, 2'd0);
      respond(32'h12803456, 3);
      exp_commits++;
      checks++; if (rf_wdata !== 32'h00003456 || rf_waddr !== 5'd8 || commit !== 1'b1) begin errors++; $display("FAIL lhu_write: wdata=%h waddr=%0d commit=%b want 00003456/8/1", rf_wdata, rf_waddr, commit); end
      @(negedge clk);
   endtask

   task automatic test_rd_zero();
      issue(5'd0, 32'h1, 1'b0, LD_WORD, 1'b0, 2'd0);
      exp_commits++;
      checks++; if (commit !== 1'b1 || rf_wen !== 1'b0) begin errors++; $display("FAIL rd0_alu: commit=%b wen=%b want 1/0", commit, rf_wen); end
      @(negedge clk);
      issue(5'd0, 32'h0, 1'b1, LD_WORD, 1'b0, 2'd0);
      checks++; if (mem_rready !== 1'b1 || commit !== 1'b0) begin errors++; $display("FAIL rd0_ld_wait: mem_rready=%b commit=%b want 1/0", mem_rready, commit); end
      respond(32'hCAFEF00D, 2);
      exp_commits++;
      checks++; if (commit !== 1'b1 || rf_wen !== 1'b0) begin errors++; $display("FAIL rd0_load: commit=%b wen=%b want 1/0", commit, rf_wen); end
      @(negedge clk);
   endtask

   task automatic test_reset_in_wait();
      issue(5'd3, 32'h0, 1'b1, LD_WORD, 1'b0, 2'd0);
      checks++; if (mem_rready !== 1'b1) begin errors++; $display("FAIL rstw_wait: mem_rready=%b want 1", mem_rready); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_commits = 0; exp_stall = 0;
      mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
      @(negedge clk);
      mem_rvalid = 1'b0;
      checks++; if (rf_wen !== 1'b0 || commit !== 1'b0) begin errors++; $display("FAIL rstw_drop: wen=%b commit=%b want 0/0", rf_wen, commit); end
      checks++; if (mem_rready !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstw_idle: mem_rready=%b in_ready=%b want 0/1", mem_rready, in_ready); end
      checks++; if (rf_waddr !== '0 || perf_commits !== 32'd0) begin errors++; $display("FAIL rstw_clear: waddr=%0d commits=%0d want 0/0", rf_waddr, perf_commits); end
   endtask

   task automatic test_random();
      logic [AW-1:0] rd;
      logic [DW-1:0] res, data, exp;
      logic [1:0]    size, lo;
      bit            ld, uns;
      int            delay;
      for (int n = 0; n < 60; n++) begin
         rd = AW'($urandom_range(0, 31)); ld = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1));
         lo = 2'($urandom_range(0, 3)); data = $urandom; res = $urandom;
         delay = $urandom_range(0, 4);
         exp_q.push_back(ld ? ref_load(data, int'(size), uns, int'(lo)) : res);
         issue(rd, res, ld, size, uns, lo);
         if (ld) respond(data, delay);
         exp_commits++;
         exp = exp_q.pop_front();
         checks++;
         if (commit !== 1'b1 || rf_wen !== (rd != 0) || rf_waddr !== rd || rf_wdata !== exp) begin
            errors++;
            $display("FAIL rand_write[%0d]: commit=%b wen=%b waddr=%0d wdata=%h want 1/%b/%0d/%h (ld=%0b size=%0d uns=%0b lo=%0d)",
                     n, commit, rf_wen, rf_waddr, rf_wdata, rd != 0, rd, exp, ld, size, uns, lo);
         end
      end
      @(negedge clk);
      checks++;
      if (perf_commits !== (PERF_EN ? exp_commits : 0) || perf_ld_stall !== (PERF_EN ? exp_stall : 0)) begin
         errors++;
         $display("FAIL rand_perf: commits=%0d stall=%0d want %0d/%0d", perf_commits, perf_ld_stall,
                  PERF_EN ? exp_commits : 0, PERF_EN ? exp_stall : 0);
      end
   endtask

   task automatic test_perf();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         issue(AW'(i), 32'(i * 100), 1'b0, LD_WORD, 1'b0, 2'd0);
         exp_commits++;
      end
      issue(5'd4, 32'h0, 1'b1, LD_WORD, 1'b0, 2'd1);
      respond(32'hA5A5A5A5, 3);
      exp_commits++;
      checks++; if (rf_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL perf_lw: wdata=%h want a5a5a5a5", rf_wdata); end
      @(negedge clk);
      checks++;
      if (perf_commits !== (PERF_EN ? exp_commits : 0) || perf_ld_stall !== (PERF_EN ? exp_stall : 0)) begin
         errors++;
         $display("FAIL perf_counts: commits=%0d stall=%0d want %0d/%0d", perf_commits, perf_ld_stall,
                  PERF_EN ? exp_commits : 0, PERF_EN ? exp_stall : 0);
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_alu();
      test_load();
      test_rd_zero();
      test_reset_in_wait();
      test_random();
      test_perf();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
